// File: rtl/cache_pkg.sv
// Shared types for the ACE-retry cache controller: line-state codes,
// ACE request types and controller states.
package cache_pkg;

   localparam logic [2:0] ST_UC = 3'd0;
   localparam logic [2:0] ST_UD = 3'd1;
   localparam logic [2:0] ST_SC = 3'd2;
   localparam logic [2:0] ST_SD = 3'd3;
   localparam logic [2:0] ST_I  = 3'd4;

   typedef enum logic [1:0] {
      ACE_READ      = 2'b00,
      ACE_WB        = 2'b01,
      ACE_CLEAN_INV = 2'b10
   } ace_req_t;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      ALLOCATE,
      INVALIDATE,
      ERROR
   } ctrl_state_t;

   // States in which an ACE request is (or is about to be re-) issued.
   function automatic logic is_wait_state(input ctrl_state_t s);
      return (s == WRITEBACK) || (s == ALLOCATE) || (s == INVALIDATE);
   endfunction

endpackage

// File: rtl/cache_ace_timer.sv
// Per-phase ACE watchdog: counts unanswered request cycles, schedules a
// one-cycle retry gap on failure and flags give_up once retries run out.
module cache_ace_timer #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic waiting,
   input  logic ack,
   input  logic err,
   output logic retry_gap,
   output logic give_up
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic [TW-1:0] timer;
   logic [RW-1:0] retry;
   logic          fail;

   // An ack always beats an expiring timer in the same cycle.
   assign fail    = waiting && ((ack && err) || (!ack && (timer == TW'(TIMEOUT_CYCLES - 1))));
   assign give_up = fail && (retry == RW'(MAX_RETRY));

   always_ff @(posedge clk) begin
      if (reset || start) begin
         timer     <= '0;
         retry     <= '0;
         retry_gap <= 1'b0;
      end else begin
         retry_gap <= fail && !give_up;
         if (fail) begin
            timer <= '0;
            if (!give_up) retry <= retry + RW'(1);
         end else if (retry_gap) begin
            timer <= '0;
         end else if (waiting && !ack) begin
            timer <= timer + TW'(1);
         end
      end
   end

endmodule

// File: rtl/cache_ctrl_ace_retry.sv
// Per-request cache controller between CPU, cache datapath and ACE, with
// bounded timeout/retry on every ACE phase and error completion.
module cache_ctrl_ace_retry
   import cache_pkg::*;
#(
   parameter int WIDTH_STATE    = 3,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_req_valid,
   input  logic                   cpu_req_write,
   output logic                   cpu_req_ready,
   input  logic                   cache_hit,
   input  logic [WIDTH_STATE-1:0] line_state,
   output logic                   ace_req_valid,
   output logic [1:0]             ace_req_type,
   input  logic                   ace_ack,
   input  logic                   ace_err,
   output logic                   write_from_cpu,
   output logic                   write_from_interconnect,
   output logic                   state_we,
   output logic [WIDTH_STATE-1:0] new_state,
   output logic                   cache_complete,
   output logic                   cache_error
);

   ctrl_state_t state, next_state;
   logic        req_write;
   logic        in_wait, ace_wait, ack_clean, timer_start;
   logic        retry_gap, give_up;
   logic        state_illegal, line_hit, line_unique, line_dirty;

   assign state_illegal = line_state > WIDTH_STATE'(ST_I);
   assign line_hit      = cache_hit && (line_state != WIDTH_STATE'(ST_I));
   assign line_unique   = (line_state == WIDTH_STATE'(ST_UC)) || (line_state == WIDTH_STATE'(ST_UD));
   assign line_dirty    = (line_state == WIDTH_STATE'(ST_UD)) || (line_state == WIDTH_STATE'(ST_SD));

   // Acks during a retry gap or outside the wait states are not ours.
   assign in_wait     = is_wait_state(state);
   assign ace_wait    = in_wait && !retry_gap;
   assign ack_clean   = ace_wait && ace_ack && !ace_err;
   assign timer_start = !in_wait || ack_clean;

   cache_ace_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MAX_RETRY     (MAX_RETRY)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .start    (timer_start),
      .waiting  (ace_wait),
      .ack      (ace_ack),
      .err      (ace_err),
      .retry_gap(retry_gap),
      .give_up  (give_up)
   );

   always_comb begin
      next_state              = state;
      cpu_req_ready           = 1'b0;
      ace_req_valid           = 1'b0;
      ace_req_type            = ACE_READ;
      write_from_cpu          = 1'b0;
      write_from_interconnect = 1'b0;
      state_we                = 1'b0;
      new_state               = '0;
      cache_complete          = 1'b0;
      cache_error             = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               cpu_req_ready = 1'b1;
               if (cpu_req_valid) next_state = LOOKUP;
            end
            LOOKUP: begin
               if (state_illegal) begin
                  next_state = ERROR;
               end else if (line_hit && !req_write) begin
                  cache_complete = 1'b1;
                  next_state     = IDLE;
               end else if (line_hit && line_unique) begin
                  write_from_cpu = 1'b1;
                  state_we       = 1'b1;
                  new_state      = WIDTH_STATE'(ST_UD);
                  cache_complete = 1'b1;
                  next_state     = IDLE;
               end else if (line_hit) begin
                  next_state = INVALIDATE;
               end else if (line_dirty) begin
                  next_state = WRITEBACK;
               end else begin
                  next_state = ALLOCATE;
               end
            end
            WRITEBACK: begin
               ace_req_valid = ace_wait;
               ace_req_type  = ACE_WB;
               if (give_up)        next_state = ERROR;
               else if (ack_clean) next_state = ALLOCATE;
            end
            ALLOCATE: begin
               ace_req_valid = ace_wait;
               ace_req_type  = ACE_READ;
               if (give_up) begin
                  next_state = ERROR;
               end else if (ack_clean) begin
                  write_from_interconnect = 1'b1;
                  state_we                = 1'b1;
                  new_state               = WIDTH_STATE'(ST_UC);
                  next_state              = LOOKUP;
               end
            end
            INVALIDATE: begin
               ace_req_valid = ace_wait;
               ace_req_type  = ACE_CLEAN_INV;
               if (give_up) begin
                  next_state = ERROR;
               end else if (ack_clean) begin
                  write_from_cpu = 1'b1;
                  state_we       = 1'b1;
                  new_state      = WIDTH_STATE'(ST_UD);
                  cache_complete = 1'b1;
                  next_state     = IDLE;
               end
            end
            ERROR: begin
               cache_complete = 1'b1;
               cache_error    = 1'b1;
               next_state     = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req_write <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && cpu_req_valid) req_write <= cpu_req_write;
      end
   end

endmodule

// File: tb/tb_cache_ctrl_ace_retry.sv
// Directed, table-driven bench for cache_ctrl_ace_retry; every cycle's
// outputs are compared against hand-computed expectations.
module tb_cache_ctrl_ace_retry;

   typedef struct packed {
      logic       rst, valid, wr, hit;
      logic [2:0] ls;
      logic       ack, err;
   } in_t;

   typedef struct packed {
      logic       ready, aval;
      logic [1:0] atype;
      logic       wfc, wfi, we;
      logic [2:0] ns;
      logic       cmp, err;
   } out_t;

   typedef struct {
      string name;
      in_t   i;
      out_t  o;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_req_valid = 1'b0, cpu_req_write = 1'b0;
   logic       cache_hit = 1'b0, ace_ack = 1'b0, ace_err = 1'b0;
   logic [2:0] line_state = 3'd0;
   logic       cpu_req_ready, ace_req_valid;
   logic [1:0] ace_req_type;
   logic       write_from_cpu, write_from_interconnect, state_we;
   logic [2:0] new_state;
   logic       cache_complete, cache_error;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   cache_ctrl_ace_retry #(
      .WIDTH_STATE(3), .TIMEOUT_CYCLES(16), .MAX_RETRY(3)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .cpu_req_valid          (cpu_req_valid),
      .cpu_req_write          (cpu_req_write),
      .cpu_req_ready          (cpu_req_ready),
      .cache_hit              (cache_hit),
      .line_state             (line_state),
      .ace_req_valid          (ace_req_valid),
      .ace_req_type           (ace_req_type),
      .ace_ack                (ace_ack),
      .ace_err                (ace_err),
      .write_from_cpu         (write_from_cpu),
      .write_from_interconnect(write_from_interconnect),
      .state_we               (state_we),
      .new_state              (new_state),
      .cache_complete         (cache_complete),
      .cache_error            (cache_error)
   );

   always #5 clk = ~clk;

   function automatic in_t fi(logic rst, logic v, logic wr, logic hit, logic [2:0] ls,
                              logic ack, logic err);
      in_t r;
      r.rst = rst; r.valid = v; r.wr = wr; r.hit = hit; r.ls = ls; r.ack = ack; r.err = err;
      return r;
   endfunction

   function automatic out_t fo(logic rdy, logic aval, logic [1:0] typ, logic wfc, logic wfi,
                               logic we, logic [2:0] ns, logic cmp, logic err);
      out_t r;
      r.ready = rdy; r.aval = aval; r.atype = typ; r.wfc = wfc; r.wfi = wfi;
      r.we = we; r.ns = ns; r.cmp = cmp; r.err = err;
      return r;
   endfunction

   function automatic void add(string n, in_t i, out_t o);
      vec_t v;
      v.name = n; v.i = i; v.o = o;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input in_t i);
      reset         = i.rst;
      cpu_req_valid = i.valid;
      cpu_req_write = i.wr;
      cache_hit     = i.hit;
      line_state    = i.ls;
      ace_ack       = i.ack;
      ace_err       = i.err;
   endtask

   task automatic checkOutput(input string n, input out_t e);
      out_t a;
      a = fo(cpu_req_ready, ace_req_valid, ace_req_type, write_from_cpu,
             write_from_interconnect, state_we, new_state, cache_complete, cache_error);
      checks++;
      if (a !== e) begin
         errors++;
         $display("[TB] FAIL %s: got rdy/av/typ/wfc/wfi/we/ns/cmp/err=%b expected %b", n, a, e);
      end
   endtask

   // Drive on the falling edge, compare 1ns later, commit on the next rising edge.
   task automatic step(input string n, input in_t i, input out_t e);
      @(negedge clk);
      applyStimulus(i);
      #1;
      checkOutput(n, e);
   endtask

   initial begin
      out_t z, rdy, fill, wr_done, rd_done;
      z       = fo(0, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0);
      rdy     = fo(1, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0);
      fill    = fo(0, 1, 2'd0, 0, 1, 1, 3'd0, 0, 0);
      wr_done = fo(0, 0, 2'd0, 1, 0, 1, 3'd1, 1, 0);
      rd_done = fo(0, 0, 2'd0, 0, 0, 0, 3'd0, 1, 0);

      add("reset_hold0",      fi(1,1,1,1,3'd0,1,0), z);
      add("reset_hold1",      fi(1,1,1,1,3'd0,1,0), z);
      add("t1_accept",        fi(0,1,0,0,3'd0,0,0), rdy);
      add("t1_rd_hit",        fi(0,0,0,1,3'd0,0,0), rd_done);
      add("idle_stray_ack",   fi(0,0,0,0,3'd0,1,0), rdy);

      add("t2_accept",        fi(0,1,1,0,3'd0,0,0), rdy);
      add("t2_lookup_sc",     fi(0,0,0,1,3'd2,0,0), z);
      add("t2_inv_wait_a",    fi(0,1,0,0,3'd0,0,0), fo(0,1,2'd2,0,0,0,3'd0,0,0));
      add("t2_inv_wait_b",    fi(0,1,0,0,3'd0,0,0), fo(0,1,2'd2,0,0,0,3'd0,0,0));
      add("t2_inv_ack",       fi(0,0,0,0,3'd0,1,0), fo(0,1,2'd2,1,0,1,3'd1,1,0));
      add("t2_idle",          fi(0,0,0,0,3'd0,0,0), rdy);

      add("ud_accept",        fi(0,1,1,0,3'd0,0,0), rdy);
      add("wr_hit_ud",        fi(0,0,0,1,3'd1,0,0), wr_done);

      add("t3_accept",        fi(0,1,1,0,3'd0,0,0), rdy);
      add("t3_lookup_sd",     fi(0,0,0,0,3'd3,0,0), z);
      add("t3_wb_wait",       fi(0,0,0,0,3'd0,0,0), fo(0,1,2'd1,0,0,0,3'd0,0,0));
      add("t3_wb_ack",        fi(0,0,0,0,3'd0,1,0), fo(0,1,2'd1,0,0,0,3'd0,0,0));
      add("t3_alloc_wait",    fi(0,0,0,0,3'd0,0,0), fo(0,1,2'd0,0,0,0,3'd0,0,0));
      add("t3_alloc_fill",    fi(0,0,0,0,3'd0,1,0), fill);
      add("t3_replay_write",  fi(0,0,0,1,3'd0,0,0), wr_done);
      add("t3_idle",          fi(0,0,0,0,3'd0,0,0), rdy);

      add("wbe_accept",       fi(0,1,1,0,3'd0,0,0), rdy);
      add("wbe_lookup_ud",    fi(0,0,0,0,3'd1,0,0), z);
      add("wbe_err_ack",      fi(0,0,0,0,3'd0,1,1), fo(0,1,2'd1,0,0,0,3'd0,0,0));
      add("wbe_gap",          fi(0,0,0,0,3'd0,0,0), fo(0,0,2'd1,0,0,0,3'd0,0,0));
      add("wbe_reissue",      fi(0,0,0,0,3'd0,0,0), fo(0,1,2'd1,0,0,0,3'd0,0,0));
      add("wbe_ack",          fi(0,0,0,0,3'd0,1,0), fo(0,1,2'd1,0,0,0,3'd0,0,0));
      add("wbe_fill",         fi(0,0,0,0,3'd0,1,0), fill);
      add("wbe_replay_write", fi(0,0,0,1,3'd0,0,0), wr_done);

      add("t5_accept",        fi(0,1,0,0,3'd0,0,0), rdy);
      add("t5_lookup_miss",   fi(0,0,0,0,3'd0,0,0), z);
      add("t5_alloc_err",     fi(0,0,0,0,3'd0,1,1), fo(0,1,2'd0,0,0,0,3'd0,0,0));
      add("t5_gap",           fi(0,0,0,0,3'd0,0,0), z);
      add("t5_reissue",       fi(0,0,0,0,3'd0,0,0), fo(0,1,2'd0,0,0,0,3'd0,0,0));
      add("t5_fill",          fi(0,0,0,0,3'd0,1,0), fill);
      add("t5_replay_read",   fi(0,0,0,1,3'd0,0,0), rd_done);
      add("t5_idle",          fi(0,0,0,0,3'd0,0,0), rdy);

      add("si_accept",        fi(0,1,0,0,3'd0,0,0), rdy);
      add("si_hit_invalid",   fi(0,0,0,1,3'd4,0,0), z);
      add("si_fill",          fi(0,0,0,0,3'd0,1,0), fill);
      add("si_replay_read",   fi(0,0,0,1,3'd0,0,0), rd_done);

      add("t6_accept",        fi(0,1,0,0,3'd0,0,0), rdy);
      add("t6_illegal",       fi(0,0,0,1,3'd6,0,0), z);
      add("t6_error_pulse",   fi(0,0,0,0,3'd0,0,0), fo(0,0,2'd0,0,0,0,3'd0,1,1));
      add("t6_idle",          fi(0,0,0,0,3'd0,0,0), rdy);

      add("rst_accept",       fi(0,1,1,0,3'd0,0,0), rdy);
      add("rst_lookup_sd",    fi(0,0,0,0,3'd3,0,0), z);
      add("rst_wb_wait",      fi(0,0,0,0,3'd0,0,0), fo(0,1,2'd1,0,0,0,3'd0,0,0));
      add("rst_mid_wb",       fi(1,0,0,0,3'd0,1,0), z);
      add("rst_released",     fi(0,0,0,0,3'd0,1,0), rdy);
      add("rst_idle",         fi(0,0,0,0,3'd0,0,0), rdy);

      foreach (vecs[k]) step(vecs[k].name, vecs[k].i, vecs[k].o);

      // No ack ever: gaps after each 16 unanswered cycles, error after the third retry.
      step("t4_accept", fi(0,1,0,0,3'd0,0,0), rdy);
      step("t4_lookup", fi(0,0,0,0,3'd2,0,0), z);
      for (int c = 1; c <= 69; c++) begin
         out_t e;
         if (c == 17 || c == 34 || c == 51) e = z;
         else if (c == 68)                   e = fo(0,0,2'd0,0,0,0,3'd0,1,1);
         else if (c == 69)                   e = rdy;
         else                                e = fo(0,1,2'd0,0,0,0,3'd0,0,0);
         step($sformatf("t4_cycle%0d", c), fi(0,0,0,0,3'd0,0,0), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
